// File: rtl/spi_dac161_slave.sv
// spi_dac161_slave: DAC161 SPI target (CPOL=1, CPHA=1); oversampled deframer, DAC code register, miso return word.
// Optional DAC161_LDAC_EN adds ldacb: write frames go to a holding register, transferred on ldacb low.
module spi_dac161_slave #(
  parameter int          FRAME_BITS  = 24,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  WRITE_CMD   = 8'h08
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb,
  input  logic                  sck,
  input  logic                  mosi,
`ifdef DAC161_LDAC_EN
  input  logic                  ldacb,
`endif
  output logic                  miso,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_load,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic [15:0]           dac_code,
  output logic                  dac_update,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] SAT  = CW'(FRAME_BITS + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] csb_s, sck_s, mosi_s;
  logic csb_d, sck_d, csb_q, sck_q, mosi_q;
  logic csb_fall, csb_rise, sck_fall, sck_rise;
  logic start, start_pend, frame_ok, wr;
  logic [CW-1:0] bit_cnt;
  logic [FRAME_BITS-1:0] shift_in, out_shift, tx_reg;
`ifdef DAC161_LDAC_EN
  logic [SYNC_STAGES-1:0] ldac_s;
  logic ldac_d, ldac_q, ldac_fall;
  logic [15:0] hold;
  assign ldac_q    = ldac_s[SYNC_STAGES-1];
  assign ldac_fall = ldac_d & ~ldac_q;
`endif
  assign csb_q    = csb_s[SYNC_STAGES-1];
  assign sck_q    = sck_s[SYNC_STAGES-1];
  assign mosi_q   = mosi_s[SYNC_STAGES-1];
  assign csb_fall = csb_d & ~csb_q;
  assign csb_rise = ~csb_d & csb_q;
  assign sck_fall = sck_d & ~sck_q;
  assign sck_rise = ~sck_d & sck_q;
  assign start    = (state == IDLE) && (csb_fall || start_pend);
  assign frame_ok = bit_cnt == FULL;
  assign wr       = (state == CHECK) && frame_ok && (shift_in[FRAME_BITS-1 -: 8] == WRITE_CMD);
  assign busy     = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csb_s  <= '1;
      sck_s  <= '1;
      mosi_s <= '0;
      csb_d  <= 1'b1;
      sck_d  <= 1'b1;
    end else begin
      csb_s  <= {csb_s[SYNC_STAGES-2:0], csb};
      sck_s  <= {sck_s[SYNC_STAGES-2:0], sck};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
      csb_d  <= csb_q;
      sck_d  <= sck_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == IDLE)  ? (start ? SHIFT : IDLE) :
               (state == SHIFT) ? (csb_rise ? CHECK : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miso       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      dac_code   <= '0;
      dac_update <= 1'b0;
      frame_err  <= 1'b0;
      bit_cnt    <= '0;
      shift_in   <= '0;
      out_shift  <= '0;
      tx_reg     <= '0;
      start_pend <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      dac_update <= 1'b0;
      frame_err  <= 1'b0;
      // a select arriving during CHECK is remembered and started from IDLE
      start_pend <= (state == CHECK) && csb_fall;
      if (state == IDLE) begin
        miso <= tx_reg[FRAME_BITS-1];
        if (tx_load) tx_reg <= tx_data;
        if (start) begin
          bit_cnt   <= '0;
          out_shift <= tx_reg;
        end
      end
      if (state == SHIFT) begin
        if (sck_rise) begin
          shift_in <= {shift_in[FRAME_BITS-2:0], mosi_q};
          bit_cnt  <= (bit_cnt == SAT) ? bit_cnt : bit_cnt + 1'b1;
        end
        if (sck_fall) begin
          miso      <= out_shift[FRAME_BITS-1];
          out_shift <= {out_shift[FRAME_BITS-2:0], 1'b0};
        end
      end
      if (state == CHECK) begin
        rx_valid  <= frame_ok;
        frame_err <= ~frame_ok;
        if (frame_ok) rx_data <= shift_in;
      end
`ifdef DAC161_LDAC_EN
      if (wr && !ldac_q) begin
        dac_code   <= shift_in[15:0];
        dac_update <= 1'b1;
      end else if (ldac_fall) begin
        dac_code   <= hold;
        dac_update <= 1'b1;
      end
`else
      if (wr) begin
        dac_code   <= shift_in[15:0];
        dac_update <= 1'b1;
      end
`endif
    end
  end
`ifdef DAC161_LDAC_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ldac_s <= '1;
      ldac_d <= 1'b1;
      hold   <= '0;
    end else begin
      ldac_s <= {ldac_s[SYNC_STAGES-2:0], ldacb};
      ldac_d <= ldac_q;
      if (wr) hold <= shift_in[15:0];
    end
  end
`endif
endmodule
